// File: rtl/seq_word_serializer_pkg.sv
// Shared types and helpers for the word serializer: FSM state encoding,
// default word width and counter sizing.
package seq_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   // ceil(log2(w)) for w in 2..32; sizes the bit counter
   function automatic int clog2_w(input int w);
      int r;
      r = 0;
      for (int i = 0; i < 6; i++) begin
         if ((1 << i) < w) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/seq_word_serializer_piso_shifter.sv
// Parallel-load shift register; presents the current serial bit from the
// end selected by MSB_FIRST.
module seq_piso_shifter #(
   parameter int   WIDTH     = 8,
   parameter logic MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             shift,
   output logic             sout
);

   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shifted;

   // Next bit moves toward the output end; the vacated end fills with 0
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
         if (MSB_FIRST) begin : g_msb
            if (gi == 0) begin : g_edge
               assign shifted[gi] = 1'b0;
            end else begin : g_mid
               assign shifted[gi] = shift_reg[gi-1];
            end
         end else begin : g_lsb
            if (gi == WIDTH - 1) begin : g_edge
               assign shifted[gi] = 1'b0;
            end else begin : g_mid
               assign shifted[gi] = shift_reg[gi+1];
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (load) begin
         shift_reg <= load_data;
      end else if (shift) begin
         shift_reg <= shifted;
      end
   end

   generate
      if (MSB_FIRST) begin : g_out_msb
         assign sout = shift_reg[WIDTH-1];
      end else begin : g_out_lsb
         assign sout = shift_reg[0];
      end
   endgenerate

endmodule

// File: rtl/seq_word_serializer.sv
// Word-to-bit serializer feeding the 1010 detector: a shifter plus a one-word
// holding register so consecutive words stream with no gap bit.
module seq_word_serializer
   import seq_pkg::*;
#(
   parameter int   WIDTH     = DEFAULT_WIDTH,
   parameter logic MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             word_done,
   output logic             underrun,
   output logic             busy
);

   localparam int             CW       = clog2_w(WIDTH);
   localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

   state_t           state_reg, state_next;
   logic [CW-1:0]    count_reg, count_next;
   logic [WIDTH-1:0] hold_reg, hold_next;
   logic             hold_full_reg, hold_full_next;
   logic             underrun_reg, underrun_next;

   logic             xfer;
   logic             last_bit;
   logic             sh_load;
   logic             sh_shift;
   logic [WIDTH-1:0] sh_data;
   logic             sh_out;

   assign in_ready = !hold_full_reg;
   assign xfer     = in_valid && in_ready;
   assign last_bit = (state_reg == ST_SHIFT) && (count_reg == LAST_CNT);

   always_comb begin
      state_next     = state_reg;
      count_next     = count_reg;
      hold_next      = hold_reg;
      hold_full_next = hold_full_reg;
      underrun_next  = 1'b0;
      sh_load        = 1'b0;
      sh_shift       = 1'b0;
      sh_data        = in_data;
      case (state_reg)
         ST_IDLE: begin
            if (xfer) begin
               sh_load    = 1'b1;
               state_next = ST_SHIFT;
               count_next = '0;
            end
         end
         ST_SHIFT: begin
            if (!last_bit) begin
               sh_shift   = 1'b1;
               count_next = count_reg + 1'b1;
               if (xfer) begin
                  hold_next      = in_data;
                  hold_full_next = 1'b1;
               end
            end else if (hold_full_reg) begin
               // in_ready is low here, so no new word can collide with the reload
               sh_load        = 1'b1;
               sh_data        = hold_reg;
               count_next     = '0;
               hold_full_next = 1'b0;
            end else if (xfer) begin
               sh_load    = 1'b1;
               count_next = '0;
            end else begin
               state_next    = ST_IDLE;
               count_next    = '0;
               underrun_next = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
            count_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         count_reg     <= '0;
         hold_full_reg <= 1'b0;
         underrun_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         count_reg     <= count_next;
         hold_full_reg <= hold_full_next;
         underrun_reg  <= underrun_next;
      end
   end

   always_ff @(posedge clk) begin
      hold_reg <= hold_next;
   end

   seq_piso_shifter #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_shifter (
      .clk       (clk),
      .load      (sh_load),
      .load_data (sh_data),
      .shift     (sh_shift),
      .sout      (sh_out)
   );

   assign dout       = (state_reg == ST_SHIFT) ? sh_out : IDLE_BIT;
   assign dout_valid = (state_reg == ST_SHIFT);
   assign word_done  = last_bit;
   assign underrun   = underrun_reg;
   assign busy       = (state_reg == ST_SHIFT) || hold_full_reg;

endmodule

// File: tb/tb_seq_word_serializer.sv
// Bench for seq_word_serializer: MSB-first and LSB-first instances driven in
// parallel, serial output compared bit by bit against a queue of expected bits.
module tb_seq_word_serializer;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] in_data;
   logic         in_valid;

   logic in_ready [2];
   logic dout     [2];
   logic dv       [2];
   logic wd       [2];
   logic ur       [2];
   logic busy     [2];

   logic q [2][$];
   int   bit_cnt [2];
   logic prev_v  [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready[0]), .dout(dout[0]), .dout_valid(dv[0]),
      .word_done(wd[0]), .underrun(ur[0]), .busy(busy[0])
   );

   seq_word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready[1]), .dout(dout[1]), .dout_valid(dv[1]),
      .word_done(wd[1]), .underrun(ur[1]), .busy(busy[1])
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic push_word(input logic [W-1:0] d);
      for (int b = W - 1; b >= 0; b--) q[0].push_back(d[b]);
      for (int b = 0; b < W; b++) q[1].push_back(d[b]);
      $display("xfer word %h accepted at %0t", d, $time);
   endtask

   // Holds in_valid until in_ready is seen at a rising edge (bounded)
   task automatic send(input logic [W-1:0] d);
      logic ok;
      ok       = 1'b0;
      in_data  = d;
      in_valid = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (in_ready[0]) begin
            push_word(d);
            ok = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk($sformatf("send_%h_accepted", d), ok, 1'b1);
   endtask

   task automatic drain();
      logic done;
      done = 1'b0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         done = (q[0].size() == 0) && (q[1].size() == 0) && !dv[0] && !dv[1];
      end
      chk("drain_complete", done, 1'b1);
   endtask

   task automatic chk_idle_state(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s_dout[%0d]", tag, i), dout[i], 1'b0);
         chk($sformatf("%s_dout_valid[%0d]", tag, i), dv[i], 1'b0);
         chk($sformatf("%s_word_done[%0d]", tag, i), wd[i], 1'b0);
         chk($sformatf("%s_underrun[%0d]", tag, i), ur[i], 1'b0);
         chk($sformatf("%s_busy[%0d]", tag, i), busy[i], 1'b0);
         chk($sformatf("%s_in_ready[%0d]", tag, i), in_ready[i], 1'b1);
      end
   endtask

   // Stream monitor: every valid bit must match the scoreboard; flags follow the stream
   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            q[i].delete();
            bit_cnt[i] = 0;
            prev_v[i]  = 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("underrun[%0d]", i), ur[i], prev_v[i] && !dv[i]);
            if (dv[i]) begin
               if (q[i].size() == 0) begin
                  chk($sformatf("unexpected_bit[%0d]", i), dv[i], 1'b0);
               end else begin
                  chk($sformatf("dout_bit[%0d]", i), dout[i], q[i].pop_front());
               end
               chk($sformatf("word_done[%0d]", i), wd[i], bit_cnt[i] == W - 1);
               bit_cnt[i] = (bit_cnt[i] + 1) % W;
            end else begin
               chk($sformatf("idle_dout[%0d]", i), dout[i], 1'b0);
               chk($sformatf("idle_word_done[%0d]", i), wd[i], 1'b0);
            end
            prev_v[i] = dv[i];
         end
      end
   end

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_idle_state("reset");

      // Single word, then underrun
      @(posedge clk); #1;
      send(8'hA5);
      chk("busy_after_xfer", busy[0], 1'b1);
      drain();

      // Back-to-back: second word parks in hold, stream stays contiguous
      @(posedge clk); #1;
      send(8'hAA);
      send(8'h55);
      chk("in_ready_hold_full", in_ready[0], 1'b0);
      chk("busy_hold_full", busy[0], 1'b1);
      drain();

      // Backpressure: third word waits for hold to free
      @(posedge clk); #1;
      send(8'h11);
      send(8'h22);
      chk("in_ready_bp", in_ready[0], 1'b0);
      send(8'h33);
      drain();

      // Reset mid-word with a word in hold
      @(posedge clk); #1;
      send(8'hFF);
      send(8'h77);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_idle_state("mid_reset");
      @(posedge clk); #1;
      send(8'h80);
      drain();

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
